// File: rtl/cpu_io_pkg.sv
// Shared constants and types for the CPU memory-mapped I/O blocks.
// Holds the register map, STATUS bit positions, transmitter FSM states and the I/O base address.
package cpu_io_pkg;

    localparam logic [12:0] IO_BASE    = 13'h1800;

    localparam logic [1:0]  IO_TXDATA  = 2'd0;
    localparam logic [1:0]  IO_STATUS  = 2'd1;
    localparam logic [1:0]  IO_DIVISOR = 2'd2;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_ACTIVE = 2;
    localparam int ST_OVF    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Divisors below 2 would make a bit shorter than the counter can express.
    function automatic logic [7:0] eff_div(input logic [7:0] d);
        return (d < 8'd2) ? 8'd2 : d;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Small synchronous FIFO whose head entry is visible on dout with no read latency.
// A push into a full FIFO is still taken when a pop happens on the same edge.
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr_q[AW-1:0]];
    // The extra pointer bit separates a full FIFO from an empty one.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 serial transmitter on the CPU bus: TXDATA, STATUS and DIVISOR registers,
// a transmit FIFO and a shifter FSM driving a registered txd line.
module io_uart_tx
    import cpu_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] addr,
    inout  wire  [7:0]  data,
    input  logic        rd,
    input  logic        wr,
    input  logic        io_sel,
    output logic        txd,
    output logic        tx_busy
);

    logic        wr_sel, rd_sel, wr_fire, rd_fire;
    logic        wr_q, rd_q;
    logic [7:0]  div_q, div_d;
    logic        ovf_q, ovf_d;
    logic        push, pop;
    logic [7:0]  fifo_dout;
    logic        fifo_full, fifo_empty;
    logic [7:0]  rd_data;
    logic        unused_addr;

    tx_state_t   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  bdiv_q, bdiv_d;
    logic        txd_q, txd_d;

    assign unused_addr = ^addr[12:2];

    // Strobes act once on their rising edge, however long the CPU holds them.
    assign wr_sel  = io_sel & wr;
    assign rd_sel  = io_sel & rd;
    assign wr_fire = wr_sel & ~wr_q;
    assign rd_fire = rd_sel & ~rd_q;
    assign push    = wr_fire && (addr[1:0] == IO_TXDATA);

    always_comb begin
        div_d = div_q;
        if (wr_fire && addr[1:0] == IO_DIVISOR) div_d = data;
        ovf_d = ovf_q;
        if (rd_fire && addr[1:0] == IO_STATUS) ovf_d = 1'b0;
        if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    io_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .din  (data),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            div_q   <= 8'(CLKS_PER_BIT);
            ovf_q   <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            bdiv_q  <= 8'd2;
            txd_q   <= 1'b1;
        end else begin
            wr_q    <= wr_sel;
            rd_q    <= rd_sel;
            div_q   <= div_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            bdiv_q  <= bdiv_d;
            txd_q   <= txd_d;
        end
    end

    // The divisor is latched per frame so a mid-frame write waits for the next START.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        bdiv_d  = bdiv_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_dout;
                    bdiv_d  = eff_div(div_q);
                    cnt_d   = eff_div(div_q);
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == 8'd1) begin
                    cnt_d   = bdiv_q;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DATA: begin
                if (cnt_q == 8'd1) begin
                    cnt_d   = bdiv_q;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            STOP: begin
                if (cnt_q == 8'd1) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_dout;
                        bdiv_d  = eff_div(div_q);
                        cnt_d   = eff_div(div_q);
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    assign txd     = txd_q;
    assign tx_busy = ~fifo_empty | (state_q != IDLE);

    always_comb begin
        rd_data = 8'h00;
        case (addr[1:0])
            IO_STATUS: begin
                rd_data[ST_FULL]   = fifo_full;
                rd_data[ST_EMPTY]  = fifo_empty;
                rd_data[ST_ACTIVE] = (state_q != IDLE);
                rd_data[ST_OVF]    = ovf_q;
            end
            IO_DIVISOR: rd_data = div_q;
            default:    rd_data = 8'h00;
        endcase
    end

    assign data = rd_sel ? rd_data : 8'hzz;

endmodule

// File: tb/tb_io_uart_tx.sv
// Scoreboard bench for io_uart_tx: register writes queue expected frames, a txd monitor decodes
// and compares every frame (bit values, bit length, contiguity, busy flag).
module tb_io_uart_tx;

    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [12:0] addr = 13'h1800;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic        io_sel = 1'b0;
    logic        txd;
    logic        tx_busy;
    wire  [7:0]  data;
    logic [7:0]  tb_data = 8'h00;
    logic        tb_drive = 1'b0;

    assign data = tb_drive ? tb_data : 8'hzz;

    io_uart_tx #(
        .CLKS_PER_BIT(16),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .data   (data),
        .rd     (rd),
        .wr     (wr),
        .io_sel (io_sel),
        .txd    (txd),
        .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] byte_v;
        int         div;
        bit         contig;
    } frame_t;

    frame_t     exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         model_pending = 0;
    int         frames_done = 0;
    int         last_end = -100;
    logic [7:0] div_model = 8'd16;
    bit         ovf_model = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int eff(input logic [7:0] d);
        return (d < 8'd2) ? 2 : int'(d);
    endfunction

    // Expected STATUS from the model: one byte in the shifter, the rest waiting in the FIFO.
    function automatic logic [7:0] exp_status();
        int queued;
        logic [7:0] s;
        queued = (model_pending > 0) ? model_pending - 1 : 0;
        s = 8'h00;
        s[0] = (queued == FIFO_DEPTH);
        s[1] = (queued == 0);
        s[2] = (model_pending > 0);
        s[3] = ovf_model;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] v, input int hold);
        @(posedge clk);
        #1;
        addr     = 13'h1800 | 13'(a);
        tb_data  = v;
        tb_drive = 1'b1;
        io_sel   = 1'b1;
        wr       = 1'b1;
        if (a == 2'd0) begin
            if (model_pending < FIFO_DEPTH + 1) begin
                exp_q.push_back('{byte_v: v, div: eff(div_model), contig: (model_pending > 0)});
                model_pending++;
            end else begin
                ovf_model = 1'b1;
            end
        end else if (a == 2'd2) begin
            div_model = v;
        end
        repeat (hold) @(posedge clk);
        #1;
        wr       = 1'b0;
        io_sel   = 1'b0;
        tb_drive = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] v);
        @(posedge clk);
        #1;
        addr   = 13'h1800 | 13'(a);
        io_sel = 1'b1;
        rd     = 1'b1;
        #2;
        v = data;
        @(posedge clk);
        #1;
        rd     = 1'b0;
        io_sel = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] v;
        bus_read(a, v);
        check(name, 32'(v), 32'(exp));
        if (a == 2'd1) ovf_model = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int w;
        w = 0;
        while (model_pending > 0 && w < max) begin
            @(negedge clk);
            w++;
        end
        if (model_pending > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idle: %0d frames still pending after %0d cycles, required 0", model_pending, max);
            model_pending = 0;
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Frame monitor: samples txd on every falling clock edge, checks each sample against the frame shape.
    initial begin : monitor
        frame_t     f;
        bit         skip;
        bit         aborted;
        bit         ok;
        logic       exp_bit;
        logic [7:0] rx_byte;
        skip = 1'b0;
        forever begin
            if (!skip) @(negedge clk);
            skip = 1'b0;
            if (reset === 1'b1 && txd === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: txd low at cycle %0d, required idle high", cyc);
                    for (int w = 0; w < 2000 && txd === 1'b0 && reset === 1'b1; w++) @(negedge clk);
                end else begin
                    f = exp_q.pop_front();
                    if (f.contig) check("frame_contig_start", 32'(cyc), 32'(last_end + 1));
                    check("busy_in_frame", 32'(tx_busy), 32'd1);
                    aborted = 1'b0;
                    ok      = 1'b1;
                    rx_byte = 8'h00;
                    for (int b = 0; b < 10 && !aborted; b++) begin
                        for (int k = 0; k < f.div && !aborted; k++) begin
                            if (b != 0 || k != 0) @(negedge clk);
                            if (reset !== 1'b1) begin
                                aborted = 1'b1;
                            end else begin
                                exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : f.byte_v[b-1];
                                if (txd !== exp_bit) ok = 1'b0;
                                if (b >= 1 && b <= 8 && k == f.div / 2) rx_byte[b-1] = txd;
                            end
                        end
                    end
                    if (!aborted) begin
                        check("frame_data", 32'(rx_byte), 32'(f.byte_v));
                        check("frame_shape_div", ok ? 32'(f.div) : 32'hbad, 32'(f.div));
                        last_end = cyc;
                        frames_done++;
                        model_pending--;
                        @(negedge clk);
                        skip = 1'b1;
                        if (model_pending == 0) check("busy_fall", 32'(tx_busy), 32'd0);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [7:0] v;
        int         fd0;
        int         n;
        logic [7:0] d;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_busy", 32'(tx_busy), 32'd0);
        check("reset_data_hiz", 32'(data === 8'hzz), 32'd1);
        reset = 1'b1;
        read_check("reset_status", 2'd1, exp_status());
        read_check("reset_divisor", 2'd2, 8'd16);
        read_check("reserved_read", 2'd3, 8'h00);

        // Single 0xA5 frame at DIV=4 with write-to-start latency.
        bus_write(2'd2, 8'd4, 1);
        bus_write(2'd0, 8'hA5, 1);
        @(negedge clk);
        check("txd_before_pop", 32'(txd), 32'd1);
        @(negedge clk);
        check("txd_start_latency", 32'(txd), 32'd0);
        wait_idle(500);

        // Back-to-back frames.
        fd0 = frames_done;
        bus_write(2'd0, 8'h01, 1);
        bus_write(2'd0, 8'h02, 1);
        bus_write(2'd0, 8'h03, 1);
        wait_idle(1000);
        check("b2b_frame_count", 32'(frames_done - fd0), 32'd3);

        // Random bursts with random divisors.
        for (int it = 0; it < 4; it++) begin
            d = 8'($urandom_range(2, 7));
            bus_write(2'd2, d, 1);
            read_check("divisor_readback", 2'd2, d);
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) bus_write(2'd0, 8'($urandom), 1);
            wait_idle(2000);
        end

        // Overflow: one in the shifter, FIFO_DEPTH queued, the sixth dropped.
        fd0 = frames_done;
        bus_write(2'd2, 8'd20, 1);
        for (int j = 0; j < 6; j++) bus_write(2'd0, 8'($urandom), 1);
        check("ovf_model_status", 32'(exp_status()), 32'h0D);
        read_check("status_overflow", 2'd1, exp_status());
        read_check("status_ovf_cleared", 2'd1, exp_status());
        wait_idle(3000);
        check("ovf_frame_count", 32'(frames_done - fd0), 32'd5);

        // One long strobe queues exactly one byte.
        fd0 = frames_done;
        bus_write(2'd2, 8'd4, 1);
        bus_write(2'd0, 8'($urandom), 5);
        wait_idle(500);
        repeat (20) @(negedge clk);
        check("long_strobe_frames", 32'(frames_done - fd0), 32'd1);
        read_check("status_after_long", 2'd1, exp_status());

        // Divisor 0 and 1 behave as 2.
        bus_write(2'd2, 8'd0, 1);
        read_check("divisor_zero", 2'd2, 8'h00);
        bus_write(2'd0, 8'($urandom), 1);
        wait_idle(500);
        bus_write(2'd2, 8'd1, 1);
        bus_write(2'd0, 8'($urandom), 1);
        bus_write(2'd0, 8'($urandom), 1);
        wait_idle(500);

        // Reset during data bit 3 aborts the frame and discards queued bytes.
        bus_write(2'd2, 8'd4, 1);
        for (int j = 0; j < 3; j++) bus_write(2'd0, 8'($urandom), 1);
        n = 0;
        while (txd !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reset_test_started", 32'(txd), 32'd0);
        repeat (4 * 4 + 1) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("reset_txd_async", 32'(txd), 32'd1);
        check("reset_busy_async", 32'(tx_busy), 32'd0);
        exp_q.delete();
        model_pending = 0;
        div_model     = 8'd16;
        ovf_model     = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        read_check("status_after_reset", 2'd1, 8'h02);
        read_check("divisor_after_reset", 2'd2, 8'd16);
        repeat (300) @(negedge clk);
        check("idle_after_reset", 32'(txd), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

Memory-mapped serial transmitter that acts as a bus responder to the RISC CPU. It decodes CPU `wr` and `rd` strobes on the shared `addr`/`data` bus, buffers written bytes in a small FIFO, and shifts them out as 8N1 frames on `txd`. It sits beside `ram`/`rom` and is selected by an `io_sel` line from the address decoder. This gives test programs an observable output channel driven by STO and LDA instructions.

## Interface
- `CLKS_PER_BIT`, 16: reset value of the baud divisor, in clocks per serial bit.
- `FIFO_DEPTH`, 4: number of transmit FIFO entries; must be a power of 2.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `addr` in 13: CPU address. Only `addr[1:0]` is decoded; `io_sel` has already qualified the high bits.
- `data` inout 8: CPU data bus. Driven only during a register read, otherwise high-Z.
- `rd` in 1: CPU read strobe, level.
- `wr` in 1: CPU write strobe, level.
- `io_sel` in 1: block select from the address decoder.
- `txd` out 1: serial output; idles high.
- `tx_busy` out 1: high while a frame is in flight or the FIFO is non-empty.

## Operation
- Register map (offset in `addr[1:0]`):
  - 0 TXDATA: write-only. A write pushes one byte into the FIFO.
  - 1 STATUS: read-only. bit0 = full, bit1 = empty, bit2 = shifter active, bit3 = overflow (sticky), bits 7:4 = 0.
  - 2 DIVISOR: read/write, 8 bits.
  - 3: reserved. Reads return 0x00; writes are ignored.
- **Write capture.** `wr_q` is `io_sel & wr` registered on `clk`. A write is accepted on the edge where `io_sel & wr` is 1 and `wr_q` is 0, so each strobe causes exactly one action however long it lasts.
- **Full FIFO.** A TXDATA write to a full FIFO is dropped and sets the overflow bit.
- **Pop and push together.** If the FIFO is full and a pop happens on the same edge as a push, the push is accepted. The count is unchanged and overflow is not set.
- **Read path.** `data` is driven combinationally from the selected register whenever `io_sel & rd` is 1.
- **Overflow clear.** The rising edge of `io_sel & rd` at offset 1 clears overflow on the following edge. An overflow set on that same edge wins.
- **Divisor values.** DIVISOR values 0 and 1 are treated as 2. A divisor written mid-frame takes effect at the next START.
- **Shifter FSM:**
  - IDLE: `txd` = 1. If the FIFO is non-empty, pop into `shreg`, load the divisor into the bit counter, and go to START.
  - START: `txd` = 0 for DIV clocks, then go to DATA with bit index 0.
  - DATA: `txd` = `shreg[0]`, LSB first. Shift right every DIV clocks. After the 8th bit go to STOP.
  - STOP: `txd` = 1 for DIV clocks. Then go to START, popping the next byte, if the FIFO is non-empty; otherwise go to IDLE.
- `txd` is a registered output and glitch-free.

## Timing
- **Reset values:** `txd` = 1, `tx_busy` = 0, `data` high-Z, FIFO empty, overflow = 0, DIVISOR = `CLKS_PER_BIT`, FSM = IDLE.
- **Reset mid-frame:** the frame is aborted. `txd` returns to 1 asynchronously and the queued bytes are discarded.
- **Write-to-start latency:** the write is accepted on edge N, the pop happens on edge N+1, and `txd` falls after edge N+1.
- **Frame length:** exactly 10·DIV clocks.
- **Back-to-back frames:** no idle gap; the next start bit immediately follows the stop bit.
- **`tx_busy`:** rises on edge N. It falls on the edge the FSM enters IDLE with the FIFO empty.

## Structure
- Package `cpu_io_pkg` holds:
  - register offsets `IO_TXDATA`, `IO_STATUS`, `IO_DIVISOR`;
  - the STATUS bit indices;
  - the 2-bit FSM state enum `tx_state_t` (IDLE, START, DATA, STOP);
  - the I/O base address 13'h1800, used by `addr_decoder` to generate `io_sel`.
- Sub-module `io_fifo`: synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
  - `dout` is the head entry, read without latency.

## Test plan
- Reset, then write 0xA5 to offset 0 with DIV = 4 → `txd` falls after the second edge. The bench samples 0,1,0,1,0,0,1,0,1,1 at 4-clock intervals and `tx_busy` drops 40 clocks after the start bit.
- Write 0x01, 0x02, 0x03 back-to-back → three contiguous 10-bit frames (120 clocks at DIV = 4) with no high gap between stop and start.
- Write 6 bytes with a long DIV → the first pops, 4 are queued, and the 6th is dropped. STATUS reads 0x0D (full, active, overflow). A second STATUS read returns 0x05.
- Hold `wr` high for 5 clocks on one write → exactly one byte is queued.
- Write DIVISOR = 0 and read back 0x00 → each bit lasts 2 clocks.
- Assert `reset` low during bit 3 of a frame → `txd` = 1 immediately. STATUS reads 0x02 and no further frames are sent.
